riscv_cache_assoc_line: RTL and testbench

//  Fully associative, move-to-front (LRU) cache between core load/store unit and word-wide memory.

---
 rtl/riscv_cache_assoc_line.sv | 225 ++++++++++++++++++++++
 tb/tb_riscv_cache_assoc_line.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_cache_assoc_line.sv
// riscv_cache_assoc_line
//   Fully associative, move-to-front (LRU) cache between the core load/store
//   unit and a word-wide memory. Lines hold LINE_WORDS 32-bit words and are
//   filled word by word on a read miss. Stores are written through with byte
//   enables and never allocate; a store hit merges the enabled bytes into the
//   cached word. invalidate_all clears every valid bit on the next edge.
//
// Ports
//   clock, reset_n            clock, asynchronous active-low reset
//   data_address/width        core byte address, access width (0 byte, 1 half, 2 word)
//   data_read/data_write      core request, held stable until data_ready
//   data_in                   store data, LSB-aligned
//   data_out                  load word shifted right by address[1:0]*8
//   data_ready                one-cycle completion pulse
//   invalidate_all            clear all valid bits
//   memory_address            word-aligned memory address
//   memory_read/memory_write  memory request, held until memory_ready
//   memory_byte_enable        byte lanes for memory_write
//   memory_out                store data aligned to its lanes
//   memory_in                 memory read data
//   memory_ready              one-cycle memory completion pulse
//   memory_address_requested  address that memory_in belongs to

module riscv_cache_assoc_line #(
  parameter int unsigned ENTRIES    = 8,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_address,
  input  logic [1:0]  data_width,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_ready,
  input  logic        invalidate_all,
  output logic [31:0] memory_address,
  output logic        memory_read,
  output logic        memory_write,
  output logic [3:0]  memory_byte_enable,
  output logic [31:0] memory_out,
  input  logic [31:0] memory_in,
  input  logic        memory_ready,
  input  logic [31:0] memory_address_requested
);

  localparam int unsigned OFF = $clog2(LINE_WORDS) + 2;
  localparam int unsigned WB  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned IW  = $clog2(ENTRIES);
  localparam int unsigned TW  = 32 - OFF;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WRITE, ST_DONE} state_t;

  state_t             state;
  logic [ENTRIES-1:0] valid;
  logic [TW-1:0]      tags  [ENTRIES];
  logic [31:0]        lines [ENTRIES][LINE_WORDS];
  // order[0] is most recently used, order[ENTRIES-1] is the eviction victim
  logic [IW-1:0]      order [ENTRIES];
  logic [IW-1:0]      new_order [ENTRIES];

  logic [IW-1:0] victim;
  logic [TW-1:0] fill_tag;
  logic [WB-1:0] fill_cnt;
  logic          fill_killed;

  logic [TW-1:0] req_tag;
  logic [WB-1:0] req_word;
  logic [4:0]    req_shift;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic [IW-1:0] touch_idx;
  logic [IW-1:0] touch_pos;
  logic          do_touch;
  logic          fill_accept;
  logic          fill_last;
  logic          install;
  logic          write_merge;
  logic [3:0]    byte_en;
  logic [31:0]   wdata;

  assign req_tag   = data_address[31:OFF];
  assign req_shift = {data_address[1:0], 3'b000};

  generate
    if (LINE_WORDS > 1) begin : g_word
      assign req_word = data_address[OFF-1:2];
    end else begin : g_noword
      assign req_word = '0;
    end
  endgenerate

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tags[i] == req_tag) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign fill_accept = (state == ST_FILL) && memory_ready &&
                       (memory_address_requested == memory_address);
  assign fill_last   = (fill_cnt == WB'(LINE_WORDS - 1));
  // an invalidate seen at any point of the fill, including the final edge, suppresses install
  assign install     = fill_accept && fill_last && !fill_killed && !invalidate_all;
  assign write_merge = (state == ST_WRITE) && memory_ready && hit && !invalidate_all;

  assign touch_idx = (state == ST_FILL) ? victim : hit_idx;
  assign do_touch  = install || write_merge ||
                     ((state == ST_IDLE) && data_read && hit);

  always_comb begin
    touch_pos = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (order[i] == touch_idx) touch_pos = IW'(i);
    end
    new_order[0] = touch_idx;
    for (int unsigned i = 1; i < ENTRIES; i++) begin
      if (i <= 32'(touch_pos)) new_order[i] = order[i-1];
      else                     new_order[i] = order[i];
    end
  end

  always_comb begin
    case (data_width)
      2'd0:    byte_en = 4'b0001 << data_address[1:0];
      2'd1:    byte_en = 4'b0011 << data_address[1:0];
      default: byte_en = 4'b1111;
    endcase
    wdata = data_in << req_shift;
  end

  always_comb begin
    memory_read        = 1'b0;
    memory_write       = 1'b0;
    memory_address     = '0;
    memory_byte_enable = '0;
    memory_out         = '0;
    case (state)
      ST_FILL: begin
        memory_read    = 1'b1;
        memory_address = {fill_tag, {OFF{1'b0}}} | ({{(32-WB){1'b0}}, fill_cnt} << 2);
      end
      ST_WRITE: begin
        memory_write       = 1'b1;
        memory_address     = {data_address[31:2], 2'b00};
        memory_byte_enable = byte_en;
        memory_out         = wdata;
      end
      default: ;
    endcase
  end

  assign data_ready = (state == ST_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      valid       <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) order[i] <= IW'(i);
      victim      <= '0;
      fill_tag    <= '0;
      fill_cnt    <= '0;
      fill_killed <= 1'b0;
      data_out    <= '0;
    end else begin
      if (do_touch) order <= new_order;
      case (state)
        ST_IDLE: begin
          if (data_read) begin
            if (hit) begin
              data_out <= lines[hit_idx][req_word] >> req_shift;
              state    <= ST_DONE;
            end else begin
              // victim is invalidated up front so its words can be overwritten safely
              victim                 <= order[ENTRIES-1];
              valid[order[ENTRIES-1]] <= 1'b0;
              fill_tag               <= req_tag;
              fill_cnt               <= '0;
              fill_killed            <= 1'b0;
              state                  <= ST_FILL;
            end
          end else if (data_write) begin
            state <= ST_WRITE;
          end
        end
        ST_FILL: begin
          if (invalidate_all) fill_killed <= 1'b1;
          if (fill_accept) begin
            if (fill_cnt == req_word) data_out <= memory_in >> req_shift;
            if (fill_last) begin
              if (install) valid[victim] <= 1'b1;
              state <= ST_DONE;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (memory_ready) begin
            data_out <= '0;
            state    <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (invalidate_all) valid <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if ((state == ST_IDLE) && data_read && !hit) tags[order[ENTRIES-1]] <= req_tag;
    if (fill_accept) lines[victim][fill_cnt] <= memory_in;
    if (write_merge) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) lines[hit_idx][req_word][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_cache_assoc_line.sv
module tb_riscv_cache_assoc_line;

  localparam int unsigned ENTRIES    = 8;
  localparam int unsigned LINE_WORDS = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] data_address;
  logic [1:0]  data_width;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_ready;
  logic        invalidate_all;
  logic [31:0] memory_address;
  logic        memory_read;
  logic        memory_write;
  logic [3:0]  memory_byte_enable;
  logic [31:0] memory_out;
  logic [31:0] memory_in;
  logic        memory_ready;
  logic [31:0] memory_address_requested;

  riscv_cache_assoc_line #(.ENTRIES(ENTRIES), .LINE_WORDS(LINE_WORDS)) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .data_address             (data_address),
    .data_width               (data_width),
    .data_read                (data_read),
    .data_write               (data_write),
    .data_in                  (data_in),
    .data_out                 (data_out),
    .data_ready               (data_ready),
    .invalidate_all           (invalidate_all),
    .memory_address           (memory_address),
    .memory_read              (memory_read),
    .memory_write             (memory_write),
    .memory_byte_enable       (memory_byte_enable),
    .memory_out               (memory_out),
    .memory_in                (memory_in),
    .memory_ready             (memory_ready),
    .memory_address_requested (memory_address_requested)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    bit          hit;
    int          req_cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // memory model: untouched words read as {~addr[15:0], addr[15:0]}
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {~a[15:0], a[15:0]};
  endfunction

  logic [31:0] rd_log[$];
  int          wr_count = 0;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [31:0] wr_addr;
  bit          resp_hold   = 1'b0;
  bit          bad_pending = 1'b0;
  bit          stray_pulse = 1'b0;
  int          last_ready_cyc = 0;

  // memory responder: one response at most every other cycle
  initial begin
    memory_ready = 1'b0;
    memory_in = '0;
    memory_address_requested = '0;
    forever begin
      @(negedge clock);
      if (memory_ready) begin
        memory_ready = 1'b0;
      end else if (stray_pulse) begin
        memory_address_requested = 32'h0000_0400;
        memory_in    = 32'h0BAD_0BAD;
        memory_ready = 1'b1;
        stray_pulse  = 1'b0;
      end else if (!resp_hold && (memory_read || memory_write)) begin
        if (bad_pending) begin
          memory_address_requested = memory_address ^ 32'h40;
          memory_in   = 32'hDEAD_BEEF;
          bad_pending = 1'b0;
        end else begin
          memory_address_requested = memory_address;
          if (memory_read) begin
            memory_in = memrd(memory_address);
            rd_log.push_back(memory_address);
          end else begin
            memory_in = '0;
            wr_be   = memory_byte_enable;
            wr_data = memory_out;
            wr_addr = memory_address;
            wr_count++;
          end
        end
        memory_ready   = 1'b1;
        last_ready_cyc = cyc;
      end
    end
  end

  // scoreboard monitor
  bit prev_dr = 1'b0;
  always @(negedge clock) begin
    if (reset_n && data_ready) begin
      checks++;
      if (prev_dr) begin
        errors++;
        $display("FAIL ready_pulse data_ready high two cycles running");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready data_out=%h", data_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (data_out !== mon_e.data) begin
          errors++;
          $display("FAIL data_out got %h expected %h", data_out, mon_e.data);
        end
        checks++;
        if (mon_e.hit && cyc != mon_e.req_cyc + 1) begin
          errors++;
          $display("FAIL hit_latency got cycle %0d expected %0d", cyc, mon_e.req_cyc + 1);
        end else if (!mon_e.hit && cyc != last_ready_cyc + 1) begin
          errors++;
          $display("FAIL miss_latency got cycle %0d expected %0d", cyc, last_ready_cyc + 1);
        end
      end
    end
    prev_dr = data_ready;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_read(input logic [31:0] addr, input int exp_reads, input string name);
    int   base;
    bit   seen;
    exp_t e;
    @(negedge clock);
    base      = rd_log.size();
    e.data    = memrd({addr[31:2], 2'b00}) >> {addr[1:0], 3'b000};
    e.hit     = (exp_reads == 0);
    e.req_cyc = cyc;
    exp_q.push_back(e);
    data_address = addr;
    data_width   = 2'd2;
    data_read    = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (data_ready) begin
        seen = 1'b1;
        break;
      end
    end
    data_read = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout waiting for data_ready", name);
      exp_q.delete();
    end
    checks++;
    if (rd_log.size() - base != exp_reads) begin
      errors++;
      $display("FAIL %s memory reads got %0d expected %0d", name, rd_log.size() - base, exp_reads);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] width, input logic [31:0] wd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd, input string name);
    int          base;
    bit          seen;
    exp_t        e;
    logic [31:0] w;
    @(negedge clock);
    base      = wr_count;
    e.data    = '0;
    e.hit     = 1'b0;
    e.req_cyc = cyc;
    exp_q.push_back(e);
    data_address = addr;
    data_width   = width;
    data_in      = wd;
    data_write   = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (data_ready) begin
        seen = 1'b1;
        break;
      end
    end
    data_write = 1'b0;
    checks++;
    if (!seen || wr_count != base + 1) begin
      errors++;
      $display("FAIL %s write count got %0d expected %0d", name, wr_count - base, 1);
      exp_q.delete();
    end
    checks++;
    if (wr_be !== exp_be) begin
      errors++;
      $display("FAIL %s byte_enable got %b expected %b", name, wr_be, exp_be);
    end
    checks++;
    if (wr_data !== exp_wd) begin
      errors++;
      $display("FAIL %s memory_out got %h expected %h", name, wr_data, exp_wd);
    end
    checks++;
    if (wr_addr !== {addr[31:2], 2'b00}) begin
      errors++;
      $display("FAIL %s memory_address got %h expected %h", name, wr_addr, {addr[31:2], 2'b00});
    end
    w = memrd({addr[31:2], 2'b00});
    for (int b = 0; b < 4; b++) if (exp_be[b]) w[8*b +: 8] = exp_wd[8*b +: 8];
    mem[{addr[31:2], 2'b00}] = w;
  endtask

  task automatic pulse_invalidate();
    @(negedge clock);
    invalidate_all = 1'b1;
    @(negedge clock);
    invalidate_all = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] got;
    reset_n        = 1'b0;
    data_address   = '0;
    data_width     = '0;
    data_read      = 1'b0;
    data_write     = 1'b0;
    data_in        = '0;
    invalidate_all = 1'b0;
    repeat (3) @(negedge clock);
    got = {data_ready, memory_read, memory_write, memory_byte_enable, 31'd0};
    checks++;
    if (got !== 38'd0) begin
      errors++;
      $display("FAIL reset_ctrl got rd=%b mr=%b mw=%b be=%b expected all 0",
               data_ready, memory_read, memory_write, memory_byte_enable);
    end
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_data_out got %h expected 0", data_out);
    end
    checks++;
    if (memory_address !== 32'h0) begin
      errors++;
      $display("FAIL reset_memory_address got %h expected 0", memory_address);
    end
    checks++;
    if (memory_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_memory_out got %h expected 0", memory_out);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_cold_fill();
    int base;
    base = rd_log.size();
    bad_pending = 1'b1;
    do_read(32'h0000_0100, LINE_WORDS, "cold_read_100");
    for (int i = 0; i < LINE_WORDS; i++) begin
      checks++;
      if (rd_log.size() <= base + i) begin
        errors++;
        $display("FAIL fill_order missing read %0d", i);
      end else if (rd_log[base+i] !== 32'h100 + 32'(i) * 4) begin
        errors++;
        $display("FAIL fill_order read %0d got %h expected %h", i, rd_log[base+i], 32'h100 + 32'(i) * 4);
      end
    end
  endtask

  task automatic test_hit();
    do_read(32'h0000_0108, 0, "hit_108");
    do_read(32'h0000_010D, 0, "hit_10d_shift");
  endtask

  task automatic test_write();
    do_write(32'h0000_0103, 2'd0, 32'h0000_005A, 4'b1000, 32'h5A00_0000, "byte_write_103");
    do_read(32'h0000_0100, 0, "read_after_byte_write");
    do_write(32'h0000_010E, 2'd1, 32'h0000_BEEF, 4'b1100, 32'hBEEF_0000, "half_write_10e");
    do_read(32'h0000_010E, 0, "read_after_half_write");
    do_write(32'h0000_0300, 2'd2, 32'h1234_5678, 4'b1111, 32'h1234_5678, "write_miss_300");
    do_read(32'h0000_0300, LINE_WORDS, "no_allocate_300");
  endtask

  task automatic test_lru();
    pulse_invalidate();
    do_read(32'h0000_0100, LINE_WORDS, "after_invalidate_100");
    pulse_invalidate();
    for (int i = 0; i < ENTRIES; i++) do_read(32'h1000 + 32'(i) * 16, LINE_WORDS, "lru_fill");
    do_read(32'h0000_1000, 0, "lru_touch_line0");
    do_read(32'h1000 + ENTRIES * 16, LINE_WORDS, "lru_fill_extra");
    do_read(32'h0000_1000, 0, "lru_line0_kept");
    do_read(32'h1000 + (ENTRIES - 1) * 16, 0, "lru_last_kept");
    do_read(32'h0000_1010, LINE_WORDS, "lru_line1_evicted");
  endtask

  task automatic test_invalidate_fill();
    int base;
    bit reached;
    base = rd_log.size();
    fork
      do_read(32'h0000_0204, LINE_WORDS, "invalidate_mid_fill");
      begin
        reached = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clock);
          if (rd_log.size() >= base + 2) begin
            reached = 1'b1;
            break;
          end
        end
        checks++;
        if (!reached) begin
          errors++;
          $display("FAIL invalidate_mid_fill fill progress got %0d expected 2", rd_log.size() - base);
        end
        invalidate_all = 1'b1;
        @(negedge clock);
        invalidate_all = 1'b0;
      end
    join
    do_read(32'h0000_0200, LINE_WORDS, "reread_200_misses");
    do_read(32'h0000_1070, LINE_WORDS, "older_line_invalidated");
  endtask

  task automatic test_reset_write();
    bit seen;
    do_read(32'h0000_0400, LINE_WORDS, "cache_400");
    @(negedge clock);
    resp_hold    = 1'b1;
    data_address = 32'h0000_0400;
    data_width   = 2'd2;
    data_in      = 32'hCAFE_F00D;
    data_write   = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (memory_write) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_write memory_write got 0 expected 1");
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (memory_write !== 1'b0 || memory_byte_enable !== 4'b0) begin
      errors++;
      $display("FAIL async_reset_write got mw=%b be=%b expected 0 0", memory_write, memory_byte_enable);
    end
    checks++;
    if (memory_address !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_address got %h expected 0", memory_address);
    end
    data_write = 1'b0;
    repeat (2) @(negedge clock);
    reset_n     = 1'b1;
    resp_hold   = 1'b0;
    stray_pulse = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (data_ready) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL stray_ready got data_ready=1 expected 0");
    end
    do_read(32'h0000_0400, LINE_WORDS, "after_reset_400");
    do_read(32'h0000_1000, LINE_WORDS, "after_reset_1000");
  endtask

  initial begin
    test_reset();
    test_cold_fill();
    test_hit();
    test_write();
    test_lru();
    test_invalidate_fill();
    test_reset_write();
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
